// File: rtl/gf_mul_masker.sv
// Serial GF(2^8) multiplier used to apply a multiplicative mask to a byte.
// One operand bit is folded in per cycle, MSB first, with reduction every step.
module gf_mul_masker #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  input  logic [7:0] r0_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       mask_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // Multiply by x with immediate reduction, so the accumulator never grows past 8 bits.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == 3'd0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = data_in;
          b_d   = r0_in;
          acc_d = 8'h00;
          cnt_d = 3'd7;
          err_d = (r0_in == 8'h00);
        end
      end
      BUSY: begin
        acc_d = xtime(acc_q) ^ (b_q[cnt_q] ? a_q : 8'h00);
        cnt_d = cnt_q - 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      acc_q <= 8'h00;
      cnt_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    data_out  = acc_q;
    mask_err  = err_q;
  end

endmodule

// File: tb/tb_gf_mul_masker.sv
// Directed self-checking bench for gf_mul_masker, with an LSB-first
// reference GF(2^8) multiplier for the exhaustive 8'h01 x r0 sweep.
module tb_gf_mul_masker;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] dataIn;
  logic [7:0] r0In;
  logic       outValid;
  logic       outReady;
  logic [7:0] dataOut;
  logic       maskErr;

  int checkCount;
  int errorCount;

  gf_mul_masker #(.POLY(8'h1B)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .data_in  (dataIn),
    .r0_in    (r0In),
    .out_valid(outValid),
    .out_ready(outReady),
    .data_out (dataOut),
    .mask_err (maskErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gfMulRef(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    logic       carry;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      carry = a[7];
      a = {a[6:0], 1'b0};
      if (carry) a = a ^ 8'h1B;
    end
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one operand pair for exactly one accept edge, then scrambles the inputs.
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] r);
    @(negedge clk);
    inValid = 1'b1;
    dataIn  = d;
    r0In    = r;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    dataIn  = ~d;
    r0In    = r ^ 8'h5A;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!outValid && lat < 20) begin
      @(negedge clk);
      dataIn = dataIn + 8'h37;
      r0In   = r0In + 8'h11;
      lat++;
    end
  endtask

  task automatic releaseResult();
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [7:0] d, input logic [7:0] r,
                       input logic [7:0] expData, input logic expErr);
    int lat;
    applyStimulus(d, r);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 16'(lat), 16'd8);
    checkOutput({tag, "_data"}, {8'h00, dataOut}, {8'h00, expData});
    checkOutput({tag, "_maskErr"}, {15'h0, maskErr}, {15'h0, expErr});
    releaseResult();
    checkOutput({tag, "_idleAfter"}, {15'h0, inReady}, 16'd1);
  endtask

  initial begin
    int lat;
    bit sawValid;
    logic [7:0] held;
    checkCount = 0;
    errorCount = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    dataIn   = 8'h00;
    r0In     = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_inReady", {15'h0, inReady}, 16'd1);
    checkOutput("reset_outValid", {15'h0, outValid}, 16'd0);
    checkOutput("reset_dataOut", {8'h00, dataOut}, 16'h0000);
    checkOutput("reset_maskErr", {15'h0, maskErr}, 16'd0);

    // Reset must win over a simultaneous accept.
    rst = 1'b1; inValid = 1'b1; dataIn = 8'h57; r0In = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; inValid = 1'b0;
    checkOutput("rstPrio_inReady", {15'h0, inReady}, 16'd1);
    checkOutput("rstPrio_maskErr", {15'h0, maskErr}, 16'd0);

    runOp("mul57x83", 8'h57, 8'h83, 8'hC1, 1'b0);
    runOp("mul57x13", 8'h57, 8'h13, 8'hFE, 1'b0);
    runOp("mul53xCA", 8'h53, 8'hCA, 8'h01, 1'b0);
    runOp("zeroMask", 8'hA5, 8'h00, 8'h00, 1'b1);

    // Hold off the consumer for five cycles while in_valid toggles.
    applyStimulus(8'h57, 8'h83);
    waitResult(lat);
    checkOutput("hold_latency", 16'(lat), 16'd8);
    held = dataOut;
    checkOutput("hold_first", {8'h00, held}, 16'h00C1);
    for (int i = 0; i < 5; i++) begin
      inValid = ~inValid;
      dataIn  = 8'hFF - 8'(i);
      r0In    = 8'h00;
      @(negedge clk);
      checkOutput("hold_data", {8'h00, dataOut}, 16'h00C1);
      checkOutput("hold_inReady", {15'h0, inReady}, 16'd0);
      checkOutput("hold_outValid", {15'h0, outValid}, 16'd1);
      checkOutput("hold_maskErr", {15'h0, maskErr}, 16'd0);
    end
    inValid = 1'b0;
    releaseResult();
    checkOutput("hold_release", {15'h0, inReady}, 16'd1);

    // Abort in the fourth BUSY cycle; no result may appear afterwards.
    applyStimulus(8'h57, 8'h83);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_inReady", {15'h0, inReady}, 16'd1);
    checkOutput("abort_outValid", {15'h0, outValid}, 16'd0);
    checkOutput("abort_dataOut", {8'h00, dataOut}, 16'h0000);
    checkOutput("abort_maskErr", {15'h0, maskErr}, 16'd0);
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("abort_noPulse", {15'h0, sawValid}, 16'd0);
    runOp("mul02x80", 8'h02, 8'h80, 8'h1B, 1'b0);

    for (int r = 0; r < 256; r++) begin
      applyStimulus(8'h01, 8'(r));
      waitResult(lat);
      checkOutput("sweep_latency", 16'(lat), 16'd8);
      checkOutput("sweep_data", {8'h00, dataOut}, {8'h00, gfMulRef(8'h01, 8'(r))});
      checkOutput("sweep_maskErr", {15'h0, maskErr}, {15'h0, (r == 0)});
      releaseResult();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/gf_mul_masker.md
GF_MUL_MASKER -- requirements
Module: gf_mul_masker

Interface
REQ-001 The block SHALL have parameter POLY, default 8'h1B, the low byte of the AES field polynomial x^8+x^4+x^3+x+1 used for reduction.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port data_in, input, 8 bits: the byte to be masked.
REQ-007 The block SHALL have port r0_in, input, 8 bits: the multiplicative mask, supplied by the nonzero mask mapper.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port data_out, output, 8 bits: the product data_in * r0_in in GF(2^8).
REQ-011 The block SHALL have port mask_err, output, 1 bit: the captured r0_in was 8'h00.

Function
REQ-012 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-013 The block SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-014 In IDLE, when in_valid = 1, the block SHALL capture data_in into A and r0_in into B, clear the accumulator, set the bit counter to 7, and go to BUSY.
REQ-015 In IDLE, the same edge SHALL also set mask_err = (r0_in == 8'h00).
REQ-016 In BUSY, each edge SHALL update the accumulator as acc <= xtime(acc) XOR (B[cnt] ? A : 0), processing bits MSB first, where xtime(v) = {v[6:0],1'b0} XOR (v[7] ? POLY : 0).
REQ-017 In BUSY, each edge SHALL decrement the counter; the edge that processes cnt = 0 SHALL move to DONE.
REQ-018 Latency SHALL be exactly 8 edges after the accept edge to out_valid = 1, with exactly 8 BUSY cycles.
REQ-019 In DONE, data_out and mask_err SHALL hold stable until out_ready = 1; on that edge the block SHALL return to IDLE.
REQ-020 There SHALL be no same-edge accept in DONE, giving a minimum of 10 cycles per operation.
REQ-021 data_out SHALL equal the accumulator at all times, and the value in DONE SHALL be the field product.
REQ-022 Inputs SHALL be ignored outside IDLE; data_in and r0_in changing during BUSY SHALL not affect the result.
REQ-023 The datapath SHALL be exactly 8 bits, and reduction SHALL be applied every iteration so no intermediate exceeds 8 bits.
REQ-024 With r0_in = 0, the block SHALL still complete in 8 cycles with data_out = 8'h00 and mask_err = 1, and SHALL not stall.
REQ-025 In DONE, the result SHALL hold indefinitely while out_ready = 0.

Reset
REQ-026 When rst = 1 at an edge, the block SHALL enter IDLE and clear acc, A, B, the counter and mask_err to 0.
REQ-027 After reset, outputs SHALL be in_ready = 1, out_valid = 0, data_out = 8'h00 and mask_err = 0.
REQ-028 rst SHALL take priority over any handshake on the same edge.
REQ-029 rst asserted in BUSY or DONE SHALL abort the operation; no out_valid pulse for the aborted operation SHALL follow.

Verification
REQ-030 The bench SHALL cover: data_in = 8'h57, r0_in = 8'h83, out_ready = 1 -> out_valid rises 8 edges after accept, data_out = 8'hC1, mask_err = 0.
REQ-031 The bench SHALL cover: 8'h57 x 8'h13 -> 8'hFE, and 8'h53 x 8'hCA -> 8'h01 (inverse pair).
REQ-032 The bench SHALL cover: r0_in = 8'h00, data_in = 8'hA5 -> data_out = 8'h00, mask_err = 1, latency unchanged.
REQ-033 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> data_out stable, in_ready = 0, and a toggling in_valid is ignored.
REQ-034 The bench SHALL cover: rst pulsed at BUSY cycle 4 -> next cycle in_ready = 1, out_valid = 0, data_out = 8'h00, and a new 8'h02 x 8'h80 operation yields 8'h1B.
REQ-035 The bench SHALL cover: 8'h01 x r0 for all 256 r0 -> data_out = r0, checked against a reference GF(2^8) model.
